spi_master: RTL and testbench

Parallel-to-serial SPI master that drives the on-board SPI slave's `sck`/`cs`/`mosi` pins. A host-side request loads one 64-bit frame: 8-bit command, 24-bit address and 32-bit data. The block shifts the frame out MSB first in SPI mode 0, with `sck` idle low and the slave sampling on the `sck` rising edge. It sits directly upstream of the slave receiver and is the only driver of its pins.

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_clk_div.sv | 43 ++++
 rtl/spi_master.sv | 145 ++++++++++++++
 tb/tb_spi_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared widths, FSM state encoding and frame helper for the
//               SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int CMD_W   = 8;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;

    localparam logic [CMD_W-1:0] CMD_WRITE = 8'hB5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [CMD_W-1:0]  cmd,
        input logic [ADDR_W-1:0] address,
        input logic [DATA_W-1:0] data
    );
        return {cmd, address, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ============================================================================
// Module      : spi_clk_div
// Description : Phase counter; tick marks the last clk cycle of each
//               CLK_DIV-cycle phase, load restarts the phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (load || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : Mode-0 SPI master shifting a 64-bit {cmd,address,data} frame
//               MSB first. Define SPI_MASTER_MISO_EN to add data-phase receive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    output logic              done,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic              sck,
    output logic              cs,
    output logic              mosi
`ifdef SPI_MASTER_MISO_EN
    ,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data
`endif
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_W - 1);

    spi_state_t         state_q, state_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic               sck_q, sck_d;
    logic               cs_q, cs_d;
    logic               done_q, done_d;
    logic               load;
    logic               tick;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                load = 1'b1;
                if (start) begin
                    sreg_d    = pack_frame(cmd, address, data);
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: if (tick) state_d = HIGH;
            HIGH: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        // mosi advances on the same edge that sck falls
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        sreg_d    = {sreg_q[FRAME_W-2:0], 1'b0};
                        state_d   = LOW;
                    end
                end
            end
            LOW:  if (tick) state_d = HIGH;
            HOLD: if (tick) state_d = GAP;
            GAP:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        sck_d  = (state_d == HIGH);
        cs_d   = (state_d == IDLE) || (state_d == GAP);
        done_d = (state_q == HOLD) && tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            done_q    <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign sck   = sck_q;
    assign cs    = cs_q;
    assign mosi  = sreg_q[FRAME_W-1];

`ifdef SPI_MASTER_MISO_EN
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    // Partial receive is only committed at done, so an aborted frame never lands.
    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        if ((state_d == HIGH) && (state_q != HIGH) &&
            (bit_cnt_q >= 6'(FRAME_W - DATA_W))) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
        end
        if (done_d) begin
            rx_data_d = rx_shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_data = rx_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module      : tb_spi_master
// Description : Scoreboard bench for spi_master with a slave capture model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master;
    import spi_pkg::*;

    localparam int N = 2;

    typedef struct {
        logic [63:0] frame;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic        done;
    logic [7:0]  cmd;
    logic [23:0] address;
    logic [31:0] data;
    logic        sck;
    logic        cs;
    logic        mosi;
`ifdef SPI_MASTER_MISO_EN
    localparam logic [31:0] RX_PAT = 32'hCAFEF00D;
    logic        miso = 1'b0;
    logic [31:0] rx_data;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    spi_master #(.CLK_DIV(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ready   (ready),
        .done    (done),
        .cmd     (cmd),
        .address (address),
        .data    (data),
        .sck     (sck),
        .cs      (cs),
        .mosi    (mosi)
`ifdef SPI_MASTER_MISO_EN
        ,
        .miso    (miso),
        .rx_data (rx_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Request side: every accepted request becomes one expected frame.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (start && ready) begin
            exp_t e;
            e.frame = {cmd, address, data};
            e.acc   = cyc;
            exp_q.push_back(e);
        end
    end

    // Slave model and timing monitor.
    logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
    logic        active = 1'b0, prev_ok = 1'b0;
    logic [63:0] cap;
    int          rises, cs_low, viol, fall_cyc, first_rise, last_rise, last_chg;
    int          rise_cyc = 0;
    int          ready_due = -100;

    always @(negedge clk) begin
        if (rst) begin
            active  = 1'b0;
            prev_ok = 1'b0;
        end else begin
            logic fell;
            fell = !cs && prev_cs;
            if (fell) begin
                check("cs_fall_expected", 64'(exp_q.size() != 0), 64'd1);
                if (prev_ok) check("cs_gap_ge_n_plus_1", 64'(cyc - rise_cyc >= N + 1), 64'd1);
                active = 1'b1; fall_cyc = cyc; rises = 0; cs_low = 0; viol = 0;
                last_rise = -1; last_chg = cyc; cap = '0; first_rise = -1;
            end
            if (active && !cs) cs_low++;
            if (active && sck && !prev_sck) begin
                if (last_rise >= 0 && cyc - last_rise != 2 * N) viol++;
                if (cyc - last_chg < N) viol++;
                cap = {cap[62:0], mosi};
                rises++;
                if (rises == 1) first_rise = cyc;
                last_rise = cyc;
            end
            if (!fell && active && !cs && mosi !== prev_mosi) begin
                if (last_rise >= 0 && cyc - last_rise < N) viol++;
                last_chg = cyc;
            end
`ifdef SPI_MASTER_MISO_EN
            if (active && rises >= 32 && rises < 64) miso = RX_PAT[63 - rises];
`endif
            if (done) begin
                check("done_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_capture",    cap, e.frame);
                    check("sck_rises",        64'(rises), 64'd64);
                    check("cs_low_cycles",    64'(cs_low), 64'(129 * N));
                    check("cs_fall_cycle",    64'(fall_cyc - e.acc), 64'd1);
                    check("first_rise_cycle", 64'(first_rise - e.acc), 64'(N + 1));
                    check("done_cycle",       64'(cyc - e.acc), 64'(129 * N + 1));
                    check("sck_mosi_timing",  64'(viol), 64'd0);
`ifdef SPI_MASTER_MISO_EN
                    check("rx_data", 64'(rx_data), 64'(RX_PAT));
`endif
                end
                active    = 1'b0;
                prev_ok   = 1'b1;
                ready_due = cyc + N;
            end
            if (cs && !prev_cs) rise_cyc = cyc;
            if (cyc == ready_due - 1) check("ready_low_in_gap", 64'(ready), 64'd0);
            if (cyc == ready_due)     check("ready_after_gap",  64'(ready), 64'd1);
        end
        prev_sck  = sck;
        prev_cs   = cs;
        prev_mosi = mosi;
    end

    task automatic send(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d);
        for (int i = 0; i < 50 * N; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        check("send_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        start = 1'b1; cmd = c; address = a; data = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_frame(input bit noise);
        bit seen = 1'b0;
        for (int i = 0; i < 300 * N; i++) begin
            @(posedge clk); #1;
            if (noise) begin
                start   = ($urandom_range(0, 3) == 0);
                cmd     = 8'($urandom);
                address = 24'($urandom);
                data    = $urandom;
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        repeat (N + 2) @(posedge clk);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; cmd = '0; address = '0; data = '0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_sck",   64'(sck),   64'd0);
        check("reset_cs",    64'(cs),    64'd1);
        check("reset_mosi",  64'(mosi),  64'd0);
        check("reset_done",  64'(done),  64'd0);
        check("reset_ready", 64'(ready), 64'd1);

        send(CMD_WRITE, 24'h123456, 32'hDEADBEEF);
        wait_frame(1'b0);
        send(8'($urandom), 24'($urandom), 32'h00000001);
        wait_frame(1'b0);
        for (int k = 0; k < 6; k++) begin
            send(8'($urandom), 24'($urandom), $urandom);
            wait_frame(1'b1);
        end

        // start held high across two frames
        @(posedge clk); #1;
        start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 700 * N; i++) begin
            @(posedge clk); #1;
            cmd = 8'($urandom); address = 24'($urandom); data = $urandom;
            @(negedge clk);
            if (done) ndone++;
            if (ndone == 2) break;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("held_start_frames", 64'(ndone), 64'd2);
        repeat (N + 2) @(posedge clk);

        // reset while bit 20 is on the wire
        send(8'($urandom), 24'($urandom), $urandom);
        repeat (41 * N) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_cs",    64'(cs),    64'd1);
        check("abort_sck",   64'(sck),   64'd0);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done",  64'(done),  64'd0);
        repeat (3 * N) @(posedge clk);
        send(8'h03, 24'($urandom), $urandom);
        wait_frame(1'b0);

        // rst and start in the same cycle
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; cmd = 8'($urandom); address = 24'($urandom); data = $urandom;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_cs",    64'(cs),    64'd1);
        check("rst_start_ready", 64'(ready), 64'd1);
        repeat (4 * N) @(posedge clk);

        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
